// File: rtl/rv_multicycle_ctrl_alu.sv
// rtl/rv_multicycle_ctrl_alu.sv - multicycle RV32I control FSM, decoders, immediate extender and ALU
module rv_multicycle_ctrl_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [24:0]     imm_field,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            IRWrite,
    output logic            MemWrite,
    output logic            AdrSrc,
    output logic            PCWrite,
    output logic            RegWrite,
    output logic [1:0]      ResultSrc,
    output logic [1:0]      ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ImmSrc,
    output logic [2:0]      ALUControl,
    output logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic [3:0]      state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    state_t state_q;
    state_t state_d;
    aluop_t alu_op;
    logic   pc_update;
    logic   branch;
    logic   ir_write_raw;
    logic   mem_write_raw;
    logic   reg_write_raw;

    logic unused_func7;
    assign unused_func7 = ^{func7[6], func7[4:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = S_FETCH;
        alu_op        = ALUOP_ADD;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        case (state_q)
            S_FETCH: begin
                state_d      = S_DECODE;
                ir_write_raw = 1'b1;
                ALUSrcB      = 2'b10;
                pc_update    = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                ResultSrc = 2'b10;
                AdrSrc    = 1'b1;
                state_d   = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                ResultSrc     = 2'b10;
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_FUNC;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_FUNC;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc     = 2'b10;
                reg_write_raw = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA   = 2'b10;
                alu_op    = ALUOP_SUB;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Holding reset low masks every write so an aborted instruction leaves no trace.
    assign IRWrite  = reset & ir_write_raw;
    assign MemWrite = reset & mem_write_raw;
    assign RegWrite = reset & reg_write_raw;
    assign PCWrite  = reset & (pc_update | (branch & zero));
    assign state    = state_q;

    always_comb begin
        case (opcode)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            ALUOP_SUB: ALUControl = 3'b001;
            ALUOP_FUNC: begin
                case (func3)
                    3'b000:  ALUControl = (opcode[5] & func7[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b100:  ALUControl = 3'b100;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (ALUControl)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b100:  alu_result = src_a ^ src_b;
            3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    // imm_field is instruction[31:7], so bit 24 is the instruction sign bit.
    always_comb begin
        case (ImmSrc)
            2'b00:   imm_ext = {{20{imm_field[24]}}, imm_field[24:13]};
            2'b01:   imm_ext = {{20{imm_field[24]}}, imm_field[24:18], imm_field[4:0]};
            2'b10:   imm_ext = {{20{imm_field[24]}}, imm_field[0], imm_field[23:18],
                                imm_field[4:1], 1'b0};
            default: imm_ext = {{12{imm_field[24]}}, imm_field[12:5], imm_field[13],
                                imm_field[23:14], 1'b0};
        endcase
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl_alu.sv
// tb/tb_rv_multicycle_ctrl_alu.sv - self-checking bench for rv_multicycle_ctrl_alu
module tb_rv_multicycle_ctrl_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [24:0] imm_field;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        IRWrite, MemWrite, AdrSrc, PCWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic        zero;
    logic [3:0]  state;

    int checks   = 0;
    int failures = 0;

    rv_multicycle_ctrl_alu #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7(func7),
        .imm_field(imm_field), .src_a(src_a), .src_b(src_b),
        .IRWrite(IRWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .imm_ext(imm_ext),
        .alu_result(alu_result), .zero(zero), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  exec_state;
        logic [2:0]  exp_ctrl;
        logic [31:0] exp_res;
    } alu_vec_t;

    typedef struct {
        logic [3:0] st;
        logic       irw;
        logic       mw;
        logic       rw;
        logic       pcw;
        logic [1:0] rsrc;
    } exp_t;

    alu_vec_t vecs[10];
    exp_t     sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
    endtask

    task automatic push(input logic [3:0] st, input logic irw, input logic mw,
                        input logic rw, input logic pcw, input logic [1:0] rsrc);
        exp_t e;
        e.st = st; e.irw = irw; e.mw = mw; e.rw = rw; e.pcw = pcw; e.rsrc = rsrc;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        exp_t e;
        int   idx = 0;
        while (sb_q.size() > 0) begin
            if (idx > 0) step();
            e = sb_q.pop_front();
            chk($sformatf("%s_state[%0d]", tag, idx), {28'd0, state}, {28'd0, e.st});
            chk($sformatf("%s_irwrite[%0d]", tag, idx), {31'd0, IRWrite}, {31'd0, e.irw});
            chk($sformatf("%s_memwrite[%0d]", tag, idx), {31'd0, MemWrite}, {31'd0, e.mw});
            chk($sformatf("%s_regwrite[%0d]", tag, idx), {31'd0, RegWrite}, {31'd0, e.rw});
            chk($sformatf("%s_pcwrite[%0d]", tag, idx), {31'd0, PCWrite}, {31'd0, e.pcw});
            chk($sformatf("%s_resultsrc[%0d]", tag, idx), {30'd0, ResultSrc}, {30'd0, e.rsrc});
            idx++;
        end
    endtask

    initial begin
        vecs[0] = '{7'b0110011, 3'b000, 7'b0100000, 32'd5, 32'd7, 4'd6, 3'b001, 32'hFFFFFFFE};
        vecs[1] = '{7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd7, 4'd6, 3'b000, 32'd12};
        vecs[2] = '{7'b0110011, 3'b000, 7'b0000000, 32'hFFFFFFFF, 32'd1, 4'd6, 3'b000, 32'd0};
        vecs[3] = '{7'b0010011, 3'b000, 7'b0100000, 32'd5, 32'd7, 4'd8, 3'b000, 32'd12};
        vecs[4] = '{7'b0110011, 3'b010, 7'b0000000, 32'h80000000, 32'd1, 4'd6, 3'b101, 32'd1};
        vecs[5] = '{7'b0010011, 3'b010, 7'b0000000, 32'd1, 32'h80000000, 4'd8, 3'b101, 32'd0};
        vecs[6] = '{7'b0110011, 3'b100, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00, 4'd6, 3'b100, 32'h0FF00FF0};
        vecs[7] = '{7'b0110011, 3'b110, 7'b0000000, 32'hF0F0F0F0, 32'h0F0F0000, 4'd6, 3'b011, 32'hFFFFF0F0};
        vecs[8] = '{7'b0010011, 3'b111, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00, 4'd8, 3'b010, 32'hF000F000};
        vecs[9] = '{7'b0110011, 3'b001, 7'b0000000, 32'd2, 32'd3, 4'd6, 3'b000, 32'd5};

        reset = 1'b0; opcode = 7'b0110011; func3 = 3'b000; func7 = 7'b0100000;
        imm_field = '0; src_a = 32'd5; src_b = 32'd7;

        do_reset();
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_irwrite", {31'd0, IRWrite}, 32'd1);
        chk("rst_pcwrite", {31'd0, PCWrite}, 32'd1);
        chk("rst_alusrcb", {30'd0, ALUSrcB}, 32'd2);
        step();
        chk("rst_next_state", {28'd0, state}, 32'd1);
        chk("decode_aluctrl", {29'd0, ALUControl}, 32'd0);
        chk("decode_alusrca", {30'd0, ALUSrcA}, 32'd1);

        // ALU / ALU-decoder vectors, observed in the execute state
        for (int i = 0; i < 10; i++) begin
            opcode = vecs[i].op; func3 = vecs[i].f3; func7 = vecs[i].f7;
            src_a = vecs[i].a; src_b = vecs[i].b;
            do_reset();
            step();
            step();
            chk($sformatf("vec%0d_state", i), {28'd0, state}, {28'd0, vecs[i].exec_state});
            chk($sformatf("vec%0d_aluctrl", i), {29'd0, ALUControl}, {29'd0, vecs[i].exp_ctrl});
            chk($sformatf("vec%0d_result", i), alu_result, vecs[i].exp_res);
            chk($sformatf("vec%0d_zero", i), {31'd0, zero}, {31'd0, (vecs[i].exp_res == 32'd0)});
        end

        // R-type sub full sequence, then reset aborting ALUWB
        opcode = 7'b0110011; func3 = 3'b000; func7 = 7'b0100000; src_a = 32'd5; src_b = 32'd7;
        do_reset();
        push(4'd0, 1, 0, 0, 1, 2'b00);
        push(4'd1, 0, 0, 0, 0, 2'b00);
        push(4'd6, 0, 0, 0, 0, 2'b00);
        push(4'd7, 0, 0, 1, 0, 2'b10);
        drain("rtype");
        reset = 1'b0;
        #1;
        chk("abort_regwrite_low", {31'd0, RegWrite}, 32'd0);
        step();
        chk("abort_state", {28'd0, state}, 32'd0);
        chk("abort_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("abort_irwrite", {31'd0, IRWrite}, 32'd0);
        reset = 1'b1;

        // lw
        opcode = 7'b0000011; imm_field = {12'hFFC, 13'h0};
        do_reset();
        chk("lw_immsrc", {30'd0, ImmSrc}, 32'd0);
        chk("lw_imm", imm_ext, 32'hFFFFFFFC);
        push(4'd0, 1, 0, 0, 1, 2'b00);
        push(4'd1, 0, 0, 0, 0, 2'b00);
        push(4'd2, 0, 0, 0, 0, 2'b00);
        push(4'd3, 0, 0, 0, 0, 2'b10);
        push(4'd4, 0, 0, 1, 0, 2'b01);
        push(4'd0, 1, 0, 0, 1, 2'b00);
        drain("lw");

        // sw
        opcode = 7'b0100011; imm_field = {7'h7F, 13'h0, 5'h18};
        do_reset();
        chk("sw_immsrc", {30'd0, ImmSrc}, 32'd1);
        chk("sw_imm", imm_ext, 32'hFFFFFFF8);
        push(4'd0, 1, 0, 0, 1, 2'b00);
        push(4'd1, 0, 0, 0, 0, 2'b00);
        push(4'd2, 0, 0, 0, 0, 2'b00);
        push(4'd5, 0, 1, 0, 0, 2'b10);
        push(4'd0, 1, 0, 0, 1, 2'b00);
        drain("sw");

        // beq taken / not taken
        opcode = 7'b1100011; imm_field = {1'b1, 6'h3F, 13'h0, 4'hE, 1'b1};
        src_a = 32'd3; src_b = 32'd3;
        do_reset();
        chk("beq_immsrc", {30'd0, ImmSrc}, 32'd2);
        chk("beq_imm", imm_ext, 32'hFFFFFFFC);
        push(4'd0, 1, 0, 0, 1, 2'b00);
        push(4'd1, 0, 0, 0, 0, 2'b00);
        push(4'd10, 0, 0, 0, 1, 2'b10);
        push(4'd0, 1, 0, 0, 1, 2'b00);
        drain("beq_taken");
        src_b = 32'd4;
        do_reset();
        push(4'd0, 1, 0, 0, 1, 2'b00);
        push(4'd1, 0, 0, 0, 0, 2'b00);
        push(4'd10, 0, 0, 0, 0, 2'b10);
        push(4'd0, 1, 0, 0, 1, 2'b00);
        drain("beq_not");

        // jal
        opcode = 7'b1101111; imm_field = 25'h0002000;
        do_reset();
        chk("jal_immsrc", {30'd0, ImmSrc}, 32'd3);
        chk("jal_imm", imm_ext, 32'h00000800);
        push(4'd0, 1, 0, 0, 1, 2'b00);
        push(4'd1, 0, 0, 0, 0, 2'b00);
        push(4'd9, 0, 0, 0, 1, 2'b10);
        push(4'd7, 0, 0, 1, 0, 2'b10);
        push(4'd0, 1, 0, 0, 1, 2'b00);
        drain("jal");

        // unknown opcode behaves as NOP
        opcode = 7'b1111111;
        do_reset();
        chk("nop_immsrc", {30'd0, ImmSrc}, 32'd0);
        push(4'd0, 1, 0, 0, 1, 2'b00);
        push(4'd1, 0, 0, 0, 0, 2'b00);
        push(4'd0, 1, 0, 0, 1, 2'b00);
        drain("nop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_multicycle_ctrl_alu.md
Name: rv_multicycle_ctrl_alu

Overview:
- Control-and-compute core of the multicycle RV32I subset processor: a main control FSM with instruction/ALU decoders, the immediate extender, and the 32-bit ALU.
- Operand muxes, register file, memory, PC, IR and ALUOut registers live outside this block.
- The ALU Zero flag feeds the branch logic internally and is also exported.

Parameters:
- XLEN, 32, datapath width. The block supports only 32.

Ports:
- clk  in  1  system clock; rising edge
- reset  in  1  synchronous, active-low reset
- opcode  in  7  instruction[6:0]
- func3  in  3  instruction[14:12]
- func7  in  7  instruction[31:25]
- imm_field  in  25  instruction[31:7]
- src_a  in  32  ALU operand A, pre-muxed externally
- src_b  in  32  ALU operand B, pre-muxed externally
- IRWrite, MemWrite, AdrSrc, PCWrite, RegWrite  out  1 each  datapath enables/selects
- ResultSrc  out  2  00 ALUResult, 01 ReadData, 10 ALUOut
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- ALUControl  out  3  current ALU operation
- imm_ext  out  32  sign-extended immediate
- alu_result  out  32  ALU result
- zero  out  1  alu_result == 0
- state  out  4  FSM state, for debug and verification

Behaviour:
- Timing: the state register is the only sequential element. All other outputs are combinational (Moore outputs from state, decoders from opcode/func fields).
- Reset: if reset==0 at a clk rising edge, state <= FETCH (0). While reset==0, IRWrite, MemWrite, PCWrite and RegWrite are forced 0. A reset asserted mid-instruction aborts it; no partial writes occur after that edge.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10. Codes 11-15 go to FETCH on the next edge with all enables 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE, by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BEQ; any other opcode -> FETCH (treated as NOP).
  - MEMADR -> MEMREAD if opcode is lw, MEMWRITE if sw.
  - MEMREAD -> MEMWB.
  - EXECR and EXECI -> ALUWB.
  - JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
- Per-state outputs (unlisted selects are 00, unlisted enables are 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=add.
  - MEMREAD: ResultSrc=10, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=10, AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=func.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=func.
  - ALUWB: ResultSrc=10, RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCUpdate=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=10, Branch=1.
- PCWrite = PCUpdate | (Branch & zero).
- ImmSrc, from opcode only: lw/I-type 00, sw 01, beq 10, jal 11, others 00.
- ALU decoder:
  - ALUOp add -> 000; ALUOp sub -> 001.
  - ALUOp func, by func3: 000 -> 001 if opcode[5]&func7[5], else 000; 010 -> 101; 100 -> 100; 110 -> 011; 111 -> 010; others -> 000.
- ALU operations:
  - 000 a+b; 001 a-b (both mod 2^32, wrap, no flags).
  - 010 a&b; 011 a|b; 100 a^b.
  - 101 signed a<b ? 1 : 0.
  - 110 and 111 result 0.
  - zero = (alu_result == 0).
- Extend (i = imm_field), each with sign bit i[24]:
  - I: sign-extend i[24:13].
  - S: sign-extend {i[24:18], i[4:0]}.
  - B: sign-extend {i[24], i[0], i[23:18], i[4:1], 0}.
  - J: sign-extend {i[24], i[12:5], i[13], i[23:14], 0}.

Test Plan:
- Reset low for 2 edges, then high: state=0, IRWrite=1, PCWrite=1, ALUSrcB=10; after the next edge state=1. Asserting reset low while state=7 gives state=0 on the next edge with RegWrite=0.
- R-type add/sub: opcode 0110011, func3 000, func7 0100000, src_a=5, src_b=7 -> FETCH, DECODE, EXECR with ALUControl=001, alu_result=0xFFFFFFFE; then ALUWB with RegWrite=1, ResultSrc=10.
- lw sequence (opcode 0000011): states 0,1,2,3,4,0; MemWrite never 1; ImmSrc=00. With imm_field giving instruction[31:20]=0xFFC, imm_ext=0xFFFFFFFC.
- sw sequence (opcode 0100011): states 0,1,2,5,0; MemWrite=1 only in state 5; S-immediate -8 extends to 0xFFFFFFF8.
- beq: src_a=src_b=3 in BEQ -> zero=1, PCWrite=1; src_a=3, src_b=4 -> PCWrite=0. B-immediate for offset -4 -> 0xFFFFFFFC.
- slt and jal:
  - slt: src_a=0x80000000, src_b=1, ALUControl=101 -> alu_result=1.
  - jal: opcode 1101111 -> states 0,1,9,7,0 with PCWrite=1 in state 9; J-immediate 2048 -> 0x00000800.
- Unknown opcode 1111111 -> DECODE goes to FETCH, no enables asserted.
